// File: rtl/sum4_pkg.sv
// Shared types, default widths and elaboration helpers for the switch-adder sequencer.
package sum4_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_N_OPS           = 4;
  localparam int DEF_OP_W            = 4;
  localparam int DEF_SUM_W           = 6;

  // Ceiling log2, returning 0 for values <= 1.
  function automatic int CLOG2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int cnt_width(input int value);
    return (CLOG2(value) < 1) ? 1 : CLOG2(value);
  endfunction

  // The result register must hold N_OPS full-scale operands without wrapping.
  function automatic bit sum_w_ok(input int n_ops, input int op_w, input int sum_w);
    return sum_w >= (op_w + CLOG2(n_ops));
  endfunction

endpackage

// File: rtl/sum4_seq_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, debounced level
// and a one-cycle strobe on each accepted press.
module btn_debounce
  import sum4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: bring the asynchronous button into the clock domain.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a change only after it has been stable long enough; strobe on a new press.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        // level is still the old value here, so 0 means this toggle is a press.
        rise  <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum4_seq_ctrl.sv
// Press-triggered sequencer: snapshots the switches and accumulates the operands
// through one shared adder, one per cycle, then presents the sum on LED.
module sum4_seq_ctrl
  import sum4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int N_OPS           = DEF_N_OPS,
  parameter int OP_W            = DEF_OP_W,
  parameter int SUM_W           = DEF_SUM_W
) (
  input  logic                   CLK100MHZ,
  input  logic                   rst,
  input  logic [N_OPS*OP_W-1:0]  SW,
  input  logic                   BTNC,
  output logic [SUM_W-1:0]       LED,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = cnt_width(N_OPS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);

  if (!sum_w_ok(N_OPS, OP_W, SUM_W)) begin : g_bad_sum_w
    $error("sum4_seq_ctrl: SUM_W too narrow for N_OPS operands of OP_W bits");
  end
  if ((N_OPS < 2) || (N_OPS > 4)) begin : g_bad_n_ops
    $error("sum4_seq_ctrl: N_OPS must be in 2..4");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [N_OPS*OP_W-1:0]   snap;
  logic [SUM_W-1:0]        acc;
  logic [OP_W-1:0]         operand;
  logic [SUM_W-1:0]        sum_p0;
  logic                    deb_level;
  logic                    deb_rise;
  logic                    start;
  logic                    load;
  logic                    step;
  logic                    finish;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .btn_in    (BTNC),
    .level     (deb_level),
    .rise      (deb_rise)
  );

  // A press strobe always coincides with the debounced level being high.
  assign start = deb_rise & deb_level;

  // Current-state register.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle datapath controls; starts arriving while busy are ignored.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        if (idx == IDX_LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: select the current operand and add it into the running sum.
  always_comb begin
    operand = snap[idx*OP_W +: OP_W];
    sum_p0  = acc + {{(SUM_W-OP_W){1'b0}}, operand};
  end

  // Snapshot of the switches taken on the accepted press; the switches are static
  // user inputs, so the single sampling edge is taken directly.
  always_ff @(posedge CLK100MHZ) begin
    if (load) begin
      snap <= SW;
    end
  end

  // Operand index and busy/done status.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      idx  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        idx  <= '0;
        busy <= 1'b1;
      end else if (step) begin
        idx <= idx + 1'b1;
        if (finish) begin
          busy <= 1'b0;
        end
      end
    end
  end

  // Accumulator and result register; LED moves only when a full sum completes.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      acc <= '0;
      LED <= '0;
    end else begin
      if (load) begin
        acc <= '0;
      end else if (step) begin
        acc <= sum_p0;
      end
      if (finish) begin
        LED <= sum_p0;
      end
    end
  end

endmodule

// File: tb/tb_sum4_seq_ctrl.sv
// Directed bench for the press-triggered switch adder (short debounce period).
module tb_sum4_seq_ctrl;

  logic        CLK100MHZ = 1'b0;
  logic        rst;
  logic [15:0] SW;
  logic        BTNC;
  logic [5:0]  LED;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  // results of the last press() call
  int         r_busy;
  int         r_done;
  int         r_lat;
  int         r_partial;
  logic [5:0] r_led;

  always #5 CLK100MHZ = ~CLK100MHZ;

  sum4_seq_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .N_OPS           (4),
    .OP_W            (4),
    .SUM_W           (6)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .SW        (SW),
    .BTNC      (BTNC),
    .LED       (LED),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK100MHZ);
  endtask

  // Hold BTNC for 'hold' cycles, release for 'tail' cycles, and record what happened.
  task automatic press(input int hold, input int tail, input bit do_flip, input logic [15:0] flip_sw);
    int first_busy;
    int done_at;
    logic [5:0] prev_led;
    r_busy = 0; r_done = 0; r_partial = 0; r_led = 'x;
    first_busy = -100; done_at = -1;
    BTNC = 1'b1;
    for (int i = 0; i < hold + tail; i++) begin
      if (i == hold) BTNC = 1'b0;
      prev_led = LED;
      @(negedge CLK100MHZ);
      if (busy) begin
        if (r_busy == 0) begin
          first_busy = i;
          if (do_flip) SW = flip_sw;
        end
        r_busy++;
      end
      if (done) begin
        r_done++;
        if (r_done == 1) begin
          done_at = i;
          r_led   = LED;
        end
      end
      if ((LED !== prev_led) && !done) r_partial++;
    end
    r_lat = done_at - first_busy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int dn;
    int gap;
    bit did_rst;

    // reset
    rst = 1'b1; BTNC = 1'b0; SW = 16'h0000;
    cyc(3);
    rst = 1'b0;
    check("reset_led", LED, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    cyc(2);

    // 1: basic sum 1+2+3+4
    SW = 16'h4321;
    press(20, 20, 1'b0, 16'h0);
    check("t1_busy_cycles", r_busy, 4);
    check("t1_done_pulses", r_done, 1);
    check("t1_led", r_led, 10);
    check("t1_latency", r_lat, 4);
    check("t1_no_partial", r_partial, 0);
    check("t1_led_hold", LED, 10);

    // 2: full scale, long hold
    SW = 16'hFFFF;
    press(100, 20, 1'b0, 16'h0);
    check("t2_led", r_led, 60);
    check("t2_done_pulses", r_done, 1);
    check("t2_busy_cycles", r_busy, 4);

    // 3: bounce too fast to ever be accepted
    bc = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      BTNC = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      @(negedge CLK100MHZ);
      if (busy) bc++;
      if (done) dn++;
    end
    check("t3_busy", bc, 0);
    check("t3_done", dn, 0);
    check("t3_led", LED, 60);

    // 4: switches change after the snapshot
    SW = 16'h1111;
    press(20, 20, 1'b1, 16'hFFFF);
    check("t4_led", r_led, 4);
    check("t4_done_pulses", r_done, 1);

    // 5: reset on the second busy cycle aborts the sum
    SW = 16'h4321;
    BTNC = 1'b1;
    bc = 0; dn = 0; did_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK100MHZ);
      if (busy) bc++;
      if (done) dn++;
      if ((bc == 2) && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1; BTNC = 1'b0;
        @(negedge CLK100MHZ);
        rst = 1'b0;
        check("t5_led_after_rst", LED, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_done_after_rst", done, 0);
      end
    end
    check("t5_rst_reached", did_rst, 1);
    check("t5_no_done", dn, 0);
    SW = 16'h0005;
    press(20, 20, 1'b0, 16'h0);
    check("t5_led_next", r_led, 5);

    // 6: start coincides with done -> back-to-back sum
    SW = 16'h1234;
    force dut.start = 1'b1;
    @(negedge CLK100MHZ);
    release dut.start;
    dn = 0;
    for (int i = 0; i < 20 && dn == 0; i++) begin
      @(negedge CLK100MHZ);
      if (done) dn = 1;
    end
    check("t6_first_done_seen", dn, 1);
    check("t6_first_led", LED, 10);
    SW = 16'h2222;
    force dut.start = 1'b1;
    @(negedge CLK100MHZ);
    release dut.start;
    check("t6_busy_immediate", busy, 1);
    check("t6_no_double_done", done, 0);
    gap = -1;
    for (int j = 2; j < 20 && gap < 0; j++) begin
      @(negedge CLK100MHZ);
      if (done) gap = j;
    end
    check("t6_done_gap", gap, 5);
    check("t6_second_led", LED, 8);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
